// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser for the host UART pin.
// It takes one byte when idle and start_i is high, then sends a start bit,
// eight data bits LSB first and a stop bit. Each bit lasts CLOCKS_PER_BAUD clocks.
// done_o marks the last clock of the stop bit. The block always spends at least
// one clock in IDLE after a frame, so the upstream stage has time to present its
// next byte before that byte is sampled.
module uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       busy_o,
  output logic       tx
);

  localparam int CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (cnt_q == CNT_MAX);

  // Next-state logic: load in IDLE, then step through one bit period at a time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = data_i;
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line level is decoded from the next state, so the registered tx pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers. An asynchronous reset abandons any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // done_o fires in the last clock of the stop bit. The next edge always
  // lands in IDLE, so the pulse lasts exactly one clock.
  assign done_o = (state_q == STOP) && baud_end;
  assign busy_o = (state_q != IDLE);
  assign tx     = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Expected bytes are queued when a
// load is driven. An independent line receiver decodes each frame and compares
// the decoded byte against the front of that queue.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int CPB_L = 868;
  localparam int FL    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic       start_i = 1'b0;
  logic       done_o, busy_o, tx;
  logic [7:0] data_l = 8'd0;
  logic       start_l = 1'b0;
  logic       done_l, busy_l, tx_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  int done_cnt = 0;
  int done_times[$];
  logic [7:0] exp_q[$];

  uart_tx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .start_i(start_i),
    .done_o(done_o), .busy_o(busy_o), .tx(tx)
  );

  uart_tx #(.CLOCKS_PER_BAUD(CPB_L)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_i(data_l), .start_i(start_l),
    .done_o(done_l), .busy_o(busy_l), .tx(tx_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record every done_o pulse of the short-baud instance.
  initial begin
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        done_cnt++;
        done_times.push_back(cyc);
      end
    end
  end

  // Line receiver: captures one whole frame from the falling start edge and
  // decodes bits at mid-period. It also checks that each bit is held for the
  // full period and that done_o appears only in the frame's last clock.
  logic        smp [0:FL-1];
  logic        mon_abort;
  int          mon_glitch, mon_done_bad;
  logic [7:0]  mon_rx;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_abort    = 1'b0;
        mon_done_bad = 0;
        for (int i = 0; i < FL; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          smp[i] = tx;
          if (done_o !== ((i == FL - 1) ? 1'b1 : 1'b0)) mon_done_bad++;
        end
        if (!mon_abort) begin
          mon_glitch = 0;
          for (int b = 0; b < 10; b++)
            for (int j = 1; j < CPB; j++)
              if (smp[b*CPB+j] !== smp[b*CPB]) mon_glitch++;
          for (int k = 0; k < 8; k++) mon_rx[k] = smp[(k+1)*CPB + CPB/2];
          check("bit_width", mon_glitch, 0);
          check("stop_bit", smp[9*CPB + CPB/2], 1);
          check("done_pos", mon_done_bad, 0);
          check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) check("rx_byte", mon_rx, exp_q.pop_front());
          frames++;
        end
      end
    end
  end

  // Wait (bounded) until done_o is seen on a falling-edge sample.
  task automatic wait_done(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o !== 1'b1 && n < lim);
    if (done_o !== 1'b1) check("done_timeout", 0, 1);
  endtask

  // One-cycle start pulse; returns just after the load edge.
  task automatic send_pulse(input logic [7:0] b, output int load_cyc);
    exp_q.push_back(b);
    data_i  = b;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    load_cyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    int base_d, base_f, base_t;
    int bad, dbad;
    logic [9:0] frame;
    logic [7:0] msg [7];
    msg = '{8'h4D, 8'h31, 8'h32, 8'h41, 8'h42, 8'h0D, 8'h0A};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_tx_l", tx_l, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 1: single byte 0x4D
    send_pulse(8'h4D, l);
    @(negedge clk);
    check("tx_fall_latency", tx, 0);
    check("busy_in_start", busy_o, 1);
    wait_done(100);
    check("done_cycle", cyc - l, 39);
    @(negedge clk);
    check("busy_after", busy_o, 0);
    check("done_single_cycle", done_o, 0);
    repeat (5) @(posedge clk); #1;

    // 2: back-to-back "M12AB\r\n" from an upstream model holding start_i high
    base_t = done_times.size();
    base_f = frames;
    data_i = msg[0];
    exp_q.push_back(msg[0]);
    start_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_done(100);
      @(posedge clk); #1;
      if (k < 6) begin
        data_i = msg[k+1];
        exp_q.push_back(msg[k+1]);
      end else begin
        start_i = 1'b0;
      end
    end
    repeat (60) @(posedge clk); #1;
    check("b2b_frames", frames - base_f, 7);
    check("b2b_dones", done_times.size() - base_t, 7);
    for (int k = 1; k < 7; k++)
      if (done_times.size() > base_t + k)
        check("b2b_pitch", done_times[base_t+k] - done_times[base_t+k-1], 41);
    check("b2b_idle_tx", tx, 1);
    check("b2b_q_empty", exp_q.size(), 0);

    // 3: data_i churns during a frame loaded with 0xA5
    base_f = frames;
    send_pulse(8'hA5, l);
    for (int n = 0; n < FL + 2; n++) begin
      @(posedge clk); #1;
      data_i = 8'($urandom);
    end
    repeat (5) @(posedge clk); #1;
    check("churn_frames", frames - base_f, 1);
    check("churn_q_empty", exp_q.size(), 0);

    // 4: start pulse in the middle of DATA is dropped
    base_d = done_cnt;
    base_f = frames;
    send_pulse(8'h3C, l);
    repeat (10) @(posedge clk); #1;
    data_i  = 8'hFF;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(100);
    repeat (60) @(posedge clk); #1;
    check("ign_dones", done_cnt - base_d, 1);
    check("ign_frames", frames - base_f, 1);
    check("ign_q_empty", exp_q.size(), 0);

    // 5: reset during data bit 3 (0xF0: bit 3 is low, so the async rise is visible)
    send_pulse(8'hF0, l);
    repeat (17) @(posedge clk); #1;
    check("pre_reset_tx", tx, 0);
    base_d = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_done", done_o, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk); #1;
    check("rst_no_done", done_cnt - base_d, 0);
    exp_q.delete();
    base_f = frames;
    send_pulse(8'h0A, l);
    wait_done(100);
    check("post_rst_done_cycle", cyc - l, 39);
    repeat (5) @(posedge clk); #1;
    check("post_rst_frames", frames - base_f, 1);
    check("post_rst_q_empty", exp_q.size(), 0);

    // 6: long baud instance, byte 0x55
    data_l  = 8'h55;
    start_l = 1'b1;
    @(posedge clk); #1;
    start_l = 1'b0;
    frame = {1'b1, 8'h55, 1'b0};
    bad  = 0;
    dbad = 0;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < CPB_L; j++) begin
        @(negedge clk);
        if (tx_l !== frame[b]) bad++;
        if (done_l !== ((b == 9 && j == CPB_L - 1) ? 1'b1 : 1'b0)) dbad++;
      end
    end
    check("long_bits", bad, 0);
    check("long_done_pos", dbad, 0);
    @(negedge clk);
    check("long_busy_after", busy_l, 0);
    check("long_tx_idle", tx_l, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
